// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event collector: per-channel edge detection into pending flags,
// serialised onto one valid/ready event port by a round-robin arbiter.
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | no event presented, evt_valid_o = 0
// S_HOLD  | event presented on evt_ch_o/evt_rise_o, held until accepted
module edge_event_arbiter #(
   parameter  int N_CH = 4,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] a_i,
   input  logic [N_CH-1:0] rise_en_i,
   input  logic [N_CH-1:0] fall_en_i,
   input  logic [N_CH-1:0] clr_ovf_i,
   input  logic            evt_ready_i,
   output logic            evt_valid_o,
   output logic [CH_W-1:0] evt_ch_o,
   output logic            evt_rise_o,
   output logic [N_CH-1:0] pending_o,
   output logic [N_CH-1:0] ovf_o
);

   typedef enum logic {S_EMPTY, S_HOLD} state_t;

   state_t          state, state_nxt;
   logic [N_CH-1:0] a_ff;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] pend_rise;
   logic [CH_W-1:0] rr;

   logic [N_CH-1:0] rise, fall, edge_det, grant, take, ovf_set;
   logic [CH_W-1:0] winner, rr_nxt;
   logic            load;

   assign rise     = ~a_ff & a_i & rise_en_i;
   assign fall     = a_ff & ~a_i & fall_en_i;
   assign edge_det = rise | fall;

   // First pending channel at or after the rr pointer, wrapping to 0.
   always_comb begin
      int  j;
      logic found;
      j      = 0;
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_CH; i++) begin
         j = int'(rr) + i;
         if (j >= N_CH) j = j - N_CH;
         if (!found && pending[j]) begin
            found  = 1'b1;
            winner = CH_W'(j);
         end
      end
   end

   assign load    = (|pending) & ((state == S_EMPTY) | evt_ready_i);
   assign grant   = load ? (N_CH'(1) << winner) : '0;
   assign rr_nxt  = (winner == CH_W'(N_CH - 1)) ? '0 : winner + CH_W'(1);
   // A channel whose pending slot is freed this cycle accepts a new edge without loss.
   assign take    = edge_det & (~pending | grant);
   assign ovf_set = edge_det & pending & ~grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load)
         state_nxt = S_HOLD;
      else if ((state == S_EMPTY) || evt_ready_i)
         state_nxt = S_EMPTY;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_ff       <= '0;
         pending    <= '0;
         pend_rise  <= '0;
         ovf_o      <= '0;
         evt_ch_o   <= '0;
         evt_rise_o <= 1'b0;
         rr         <= '0;
      end else begin
         a_ff      <= a_i;
         pending   <= (pending & ~grant) | edge_det;
         pend_rise <= (pend_rise & ~take) | (rise & take);
         ovf_o     <= (ovf_o & ~clr_ovf_i) | ovf_set;
         if (load) begin
            evt_ch_o   <= winner;
            evt_rise_o <= pend_rise[winner];
            rr         <= rr_nxt;
         end
      end
   end

   assign evt_valid_o = (state == S_HOLD);
   assign pending_o   = pending;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: vector table for the main sequences,
// hand-written sequences for enables, fairness and mid-operation reset.
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] a_i = '0, rise_en_i = '0, fall_en_i = '0, clr_ovf_i = '0;
   logic       evt_ready_i = 1'b0;
   logic       evt_valid_o;
   logic [1:0] evt_ch_o;
   logic       evt_rise_o;
   logic [3:0] pending_o, ovf_o;

   int errors = 0;
   int checks = 0;

   edge_event_arbiter #(.N_CH(4)) dut (
      .clk(clk), .reset(reset), .a_i(a_i), .rise_en_i(rise_en_i),
      .fall_en_i(fall_en_i), .clr_ovf_i(clr_ovf_i), .evt_ready_i(evt_ready_i),
      .evt_valid_o(evt_valid_o), .evt_ch_o(evt_ch_o), .evt_rise_o(evt_rise_o),
      .pending_o(pending_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] a, ren, fen, clr;
      logic       rdy;
      logic       ev;
      logic [1:0] ch;
      logic       er;
      logic [3:0] pend, ovf;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      a_i = '0; clr_ovf_i = '0;
      step();
      reset = 1'b1;
   endtask

   function automatic vec_t mk(logic rst, logic [3:0] a, logic [3:0] ren, logic [3:0] fen,
                               logic [3:0] clr, logic rdy, logic ev, logic [1:0] ch,
                               logic er, logic [3:0] pend, logic [3:0] ovf);
      vec_t v;
      v.rst = rst; v.a = a; v.ren = ren; v.fen = fen; v.clr = clr; v.rdy = rdy;
      v.ev = ev; v.ch = ch; v.er = er; v.pend = pend; v.ovf = ovf;
      return v;
   endfunction

   int n_ev, n_rise, loads, got3;
   logic ovf0_seen;

   initial begin
      // single rise on ch2
      vt.push_back(mk(1, 4'b0000, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b0000, 0));
      vt.push_back(mk(0, 4'b0100, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b0100, 0));
      vt.push_back(mk(0, 4'b0100, 4'hf, 4'hf, 0, 1, 1, 2, 1, 4'b0000, 0));
      vt.push_back(mk(0, 4'b0100, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b0000, 0));
      // simultaneous rises, then falls (ch0 first again shows rr back at 0)
      vt.push_back(mk(1, 4'b1011, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b1011, 0));
      vt.push_back(mk(0, 4'b1011, 4'hf, 4'hf, 0, 1, 1, 0, 1, 4'b1010, 0));
      vt.push_back(mk(0, 4'b1011, 4'hf, 4'hf, 0, 1, 1, 1, 1, 4'b1000, 0));
      vt.push_back(mk(0, 4'b1011, 4'hf, 4'hf, 0, 1, 1, 3, 1, 4'b0000, 0));
      vt.push_back(mk(0, 4'b1011, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b0000, 0));
      vt.push_back(mk(0, 4'b0000, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b1011, 0));
      vt.push_back(mk(0, 4'b0000, 4'hf, 4'hf, 0, 1, 1, 0, 0, 4'b1010, 0));
      vt.push_back(mk(0, 4'b0000, 4'hf, 4'hf, 0, 1, 1, 1, 0, 4'b1000, 0));
      vt.push_back(mk(0, 4'b0000, 4'hf, 4'hf, 0, 1, 1, 3, 0, 4'b0000, 0));
      vt.push_back(mk(0, 4'b0000, 4'hf, 4'hf, 0, 1, 0, 0, 0, 4'b0000, 0));
      // backpressure and overflow on ch1
      vt.push_back(mk(1, 4'b0010, 4'hf, 4'hf, 0,       0, 0, 0, 0, 4'b0010, 4'b0000));
      vt.push_back(mk(0, 4'b0000, 4'hf, 4'hf, 0,       0, 1, 1, 1, 4'b0010, 4'b0000));
      vt.push_back(mk(0, 4'b0010, 4'hf, 4'hf, 0,       0, 1, 1, 1, 4'b0010, 4'b0010));
      vt.push_back(mk(0, 4'b0010, 4'hf, 4'hf, 0,       1, 1, 1, 0, 4'b0000, 4'b0010));
      vt.push_back(mk(0, 4'b0010, 4'hf, 4'hf, 0,       1, 0, 0, 0, 4'b0000, 4'b0010));
      vt.push_back(mk(0, 4'b0010, 4'hf, 4'hf, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000));
      vt.push_back(mk(0, 4'b0010, 4'hf, 4'hf, 0,       1, 0, 0, 0, 4'b0000, 4'b0000));

      step();
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].rst) do_reset();
         a_i = vt[i].a; rise_en_i = vt[i].ren; fall_en_i = vt[i].fen;
         clr_ovf_i = vt[i].clr; evt_ready_i = vt[i].rdy;
         step();
         chk($sformatf("v%0d valid", i), 32'(evt_valid_o), 32'(vt[i].ev));
         if (vt[i].ev) begin
            chk($sformatf("v%0d ch", i), 32'(evt_ch_o), 32'(vt[i].ch));
            chk($sformatf("v%0d rise", i), 32'(evt_rise_o), 32'(vt[i].er));
         end
         chk($sformatf("v%0d pending", i), 32'(pending_o), 32'(vt[i].pend));
         chk($sformatf("v%0d ovf", i), 32'(ovf_o), 32'(vt[i].ovf));
      end
      clr_ovf_i = '0;

      // enables: fall disabled on ch0 -> one rise event; rise disabled too -> none
      do_reset();
      rise_en_i = 4'hf; fall_en_i = 4'b1110; evt_ready_i = 1'b1;
      n_ev = 0; n_rise = 0;
      for (int c = 0; c < 8; c++) begin
         a_i = (c < 3) ? 4'b0001 : 4'b0000;
         step();
         if (evt_valid_o) begin
            n_ev++;
            if (evt_rise_o && evt_ch_o == 2'd0) n_rise++;
         end
      end
      chk("en_fall_off events", 32'(n_ev), 32'd1);
      chk("en_fall_off rise", 32'(n_rise), 32'd1);
      rise_en_i = 4'b1110;
      n_ev = 0;
      for (int c = 0; c < 8; c++) begin
         a_i = (c < 3) ? 4'b0001 : 4'b0000;
         step();
         if (evt_valid_o) n_ev++;
      end
      chk("en_both_off events", 32'(n_ev), 32'd0);

      // fairness: ch0 rises every other cycle, ch3 pending
      do_reset();
      rise_en_i = 4'hf; fall_en_i = 4'b1110; evt_ready_i = 1'b1;
      a_i = 4'b1001;
      step();
      chk("fair pending", 32'(pending_o), 32'b1001);
      loads = 0; got3 = 0; ovf0_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         a_i[0] = ~a_i[0];
         step();
         if (evt_valid_o) begin
            loads++;
            if (evt_ch_o == 2'd3 && got3 == 0) got3 = loads;
         end
         if (ovf_o[0]) ovf0_seen = 1'b1;
      end
      chk("fair ch3 load index", 32'(got3), 32'd2);
      chk("fair ch0 ovf", 32'(ovf0_seen), 32'd0);

      // reset mid-operation
      do_reset();
      rise_en_i = 4'hf; fall_en_i = 4'hf; evt_ready_i = 1'b0;
      a_i = 4'b0001;
      step();
      a_i = 4'b0111;
      step();
      step();
      chk("rstmid valid before", 32'(evt_valid_o), 32'd1);
      chk("rstmid pending before", 32'(pending_o), 32'b0110);
      #3;
      reset = 1'b0; a_i = '0;
      #1;
      chk("rstmid valid", 32'(evt_valid_o), 32'd0);
      chk("rstmid ch", 32'(evt_ch_o), 32'd0);
      chk("rstmid rise", 32'(evt_rise_o), 32'd0);
      chk("rstmid pending", 32'(pending_o), 32'd0);
      chk("rstmid ovf", 32'(ovf_o), 32'd0);
      #2;
      reset = 1'b1; evt_ready_i = 1'b1;
      n_ev = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (evt_valid_o || pending_o != 4'b0000) n_ev++;
      end
      chk("rstmid no events after", 32'(n_ev), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
